// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundle of the byte-wide RAM port, the instruction-fetch port and
//            the load/store port that meet at the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
  // RAM side: one byte per cycle
  logic        mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;

  // instruction fetch side: always a 32-bit word
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;

  // load/store side: byte, half or word, read or write
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  // the arbiter itself
  modport slave (
    output mem_wr, mem_a, mem_dout, if_done, if_data, ls_done, ls_rdata,
    input  mem_din, if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata
  );

  // the clients and the RAM seen from outside the arbiter
  modport master (
    input  mem_wr, mem_a, mem_dout, if_done, if_data, ls_done, ls_rdata,
    output mem_din, if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one byte-wide RAM port between instruction fetch and the
//            load/store unit. Multi-byte accesses are serialised one byte per
//            cycle; LSU has priority but fetch is guaranteed a slot after two
//            consecutive contested LSU grants. A one-cycle cool-down separates
//            transactions.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter (
  input  wire logic         clk_in,
  input  wire logic         rst_in,
  input  wire logic         rdy_in,
  input  wire logic         flush_in,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_COOL = 2'd2
  } state_t;

  localparam logic c_OWN_FETCH = 1'b0;
  localparam logic c_OWN_LSU   = 1'b1;

  // registered state
  state_t      r_state;
  logic        r_owner;
  logic [1:0]  r_cnt;
  logic [1:0]  r_last;
  logic [1:0]  r_streak;
  logic [31:0] r_addr;
  logic        r_wr;
  logic [31:0] r_wdata;
  logic [31:0] r_result;
  logic        r_mem_wr;
  logic [31:0] r_mem_a;
  logic [7:0]  r_mem_dout;
  logic        r_if_done;
  logic        r_ls_done;
  logic [31:0] r_if_data;
  logic [31:0] r_ls_rdata;

  // next-state values
  state_t      w_state;
  logic        w_owner;
  logic [1:0]  w_cnt;
  logic [1:0]  w_last;
  logic [1:0]  w_streak;
  logic [31:0] w_addr;
  logic        w_wr;
  logic [31:0] w_wdata;
  logic [31:0] w_result;
  logic        w_mem_wr;
  logic [31:0] w_mem_a;
  logic [7:0]  w_mem_dout;
  logic        w_if_done;
  logic        w_ls_done;
  logic [31:0] w_if_data;
  logic [31:0] w_ls_rdata;

  // helpers
  logic        w_grant_ls;
  logic        w_grant_if;
  logic [1:0]  w_cnt_inc;
  logic [4:0]  w_lane_sh;
  logic [31:0] w_captured;
  logic [7:0]  w_wbyte;

  // Next-state and output decode: arbitration, byte sequencing, flush abort
  always_comb begin
    w_state    = r_state;
    w_owner    = r_owner;
    w_cnt      = r_cnt;
    w_last     = r_last;
    w_streak   = r_streak;
    w_addr     = r_addr;
    w_wr       = r_wr;
    w_wdata    = r_wdata;
    w_result   = r_result;
    w_mem_wr   = r_mem_wr;
    w_mem_a    = r_mem_a;
    w_mem_dout = r_mem_dout;
    w_if_done  = 1'b0;
    w_ls_done  = 1'b0;
    w_if_data  = r_if_data;
    w_ls_rdata = r_ls_rdata;
    w_grant_ls = 1'b0;
    w_grant_if = 1'b0;

    // mem_din belongs to the address driven since the previous edge (lane r_cnt)
    w_cnt_inc  = r_cnt + 2'd1;
    w_lane_sh  = {r_cnt, 3'b000};
    w_captured = (r_result & ~(32'h0000_00FF << w_lane_sh))
               | ({24'h00_0000, bus.mem_din} << w_lane_sh);

    case (w_cnt_inc)
      2'd0:    w_wbyte = r_wdata[7:0];
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      default: w_wbyte = r_wdata[31:24];
    endcase

    case (r_state)
      ST_IDLE: begin
        // LSU wins unless it has already taken two contested grants in a row
        w_grant_ls = bus.ls_req && !((r_streak == 2'd2) && bus.if_req);
        w_grant_if = !w_grant_ls && bus.if_req;
        if (!flush_in && w_grant_ls) begin
          w_state    = ST_BUSY;
          w_owner    = c_OWN_LSU;
          w_cnt      = 2'd0;
          w_addr     = bus.ls_addr;
          w_wr       = bus.ls_wr;
          w_wdata    = bus.ls_wdata;
          w_result   = 32'h0;
          w_mem_a    = bus.ls_addr;
          w_mem_wr   = bus.ls_wr;
          if (bus.ls_wr) begin
            w_mem_dout = bus.ls_wdata[7:0];
          end
          case (bus.ls_size)
            2'd0:    w_last = 2'd0;
            2'd1:    w_last = 2'd1;
            default: w_last = 2'd3;
          endcase
          if (bus.if_req) begin
            w_streak = (r_streak == 2'd2) ? 2'd2 : r_streak + 2'd1;
          end else begin
            w_streak = 2'd0;
          end
        end else if (!flush_in && w_grant_if) begin
          w_state  = ST_BUSY;
          w_owner  = c_OWN_FETCH;
          w_cnt    = 2'd0;
          w_last   = 2'd3;
          w_addr   = bus.if_addr;
          w_wr     = 1'b0;
          w_result = 32'h0;
          w_mem_a  = bus.if_addr;
          w_mem_wr = 1'b0;
          w_streak = 2'd0;
        end
      end

      ST_BUSY: begin
        if (flush_in && !r_wr) begin
          // reads are speculative and can be dropped; writes must complete
          w_state  = ST_IDLE;
          w_cnt    = 2'd0;
          w_mem_a  = 32'h0;
          w_mem_wr = 1'b0;
        end else if (r_cnt == r_last) begin
          w_state  = ST_COOL;
          w_cnt    = 2'd0;
          w_mem_a  = 32'h0;
          w_mem_wr = 1'b0;
          if (!r_wr) begin
            w_result = w_captured;
          end
          if (r_owner == c_OWN_LSU) begin
            w_ls_done = 1'b1;
            if (!r_wr) begin
              w_ls_rdata = w_captured;
            end
          end else begin
            w_if_done = 1'b1;
            w_if_data = w_captured;
          end
        end else begin
          w_cnt   = w_cnt_inc;
          w_mem_a = r_addr + {30'h0, w_cnt_inc};
          if (r_wr) begin
            w_mem_dout = w_wbyte;
          end else begin
            w_result = w_captured;
          end
        end
      end

      ST_COOL: begin
        w_state = ST_IDLE;
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  // State register: reset overrides everything, low ready freezes everything
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_owner    <= c_OWN_FETCH;
      r_cnt      <= 2'd0;
      r_last     <= 2'd0;
      r_streak   <= 2'd0;
      r_addr     <= 32'h0;
      r_wr       <= 1'b0;
      r_wdata    <= 32'h0;
      r_result   <= 32'h0;
      r_mem_wr   <= 1'b0;
      r_mem_a    <= 32'h0;
      r_mem_dout <= 8'h0;
      r_if_done  <= 1'b0;
      r_ls_done  <= 1'b0;
      r_if_data  <= 32'h0;
      r_ls_rdata <= 32'h0;
    end else if (rdy_in) begin
      r_state    <= w_state;
      r_owner    <= w_owner;
      r_cnt      <= w_cnt;
      r_last     <= w_last;
      r_streak   <= w_streak;
      r_addr     <= w_addr;
      r_wr       <= w_wr;
      r_wdata    <= w_wdata;
      r_result   <= w_result;
      r_mem_wr   <= w_mem_wr;
      r_mem_a    <= w_mem_a;
      r_mem_dout <= w_mem_dout;
      r_if_done  <= w_if_done;
      r_ls_done  <= w_ls_done;
      r_if_data  <= w_if_data;
      r_ls_rdata <= w_ls_rdata;
    end
  end

  assign bus.mem_wr   = r_mem_wr;
  assign bus.mem_a    = r_mem_a;
  assign bus.mem_dout = r_mem_dout;
  assign bus.if_done  = r_if_done;
  assign bus.if_data  = r_if_data;
  assign bus.ls_done  = r_ls_done;
  assign bus.ls_rdata = r_ls_rdata;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have port clk_in, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port rdy_in, input, 1 bit: global ready; low freezes the block.
REQ-004 SHALL have port flush_in, input, 1 bit: mispredict flush from the ROB.
REQ-005 SHALL have RAM port outputs: mem_wr (1 bit, 1=write, 0=read), mem_a (32 bits, byte address), mem_dout (8 bits, write byte).
REQ-006 SHALL have RAM port input mem_din, 8 bits: read byte, valid one cycle after its address.
REQ-007 SHALL have fetch port inputs if_req (1 bit) and if_addr (32 bits), and outputs if_done (1-cycle pulse) and if_data (32 bits, little-endian).
REQ-008 SHALL have LSU port inputs ls_req (1 bit), ls_wr (1 bit), ls_size (2 bits: 0=byte, 1=half, 2=word, 3=word), ls_addr (32 bits) and ls_wdata (32 bits), and outputs ls_done (1-cycle pulse) and ls_rdata (32 bits, zero-filled above the accessed size).

Function
REQ-009 SHALL implement states IDLE, BUSY and COOL, with owner register (FETCH or LSU), byte counter cnt (0..3), length n (fetch 4; LSU 1/2/4 from ls_size) and streak counter lsu_streak (0..2).
REQ-010 SHALL, in IDLE with no request, drive mem_wr=0 and mem_a=0.
REQ-011 SHALL arbitrate in IDLE as follows:
- grant LSU if ls_req=1, unless lsu_streak=2 and if_req=1;
- otherwise grant fetch if if_req=1.
REQ-012 SHALL update lsu_streak on each grant:
- LSU grant while if_req=1: increment, saturating at 2;
- fetch grant, or LSU grant with if_req=0: clear to 0.
REQ-013 SHALL, at the grant edge E0, latch owner, address, size, wr and wdata; drive mem_a=addr, cnt=0, mem_wr=ls_wr (0 for fetch); state goes to BUSY.
REQ-014 SHALL, at edge Ei (i=1..n-1), drive mem_a=addr+i; 32-bit add wraps modulo 2^32.
REQ-015 SHALL, for reads, capture mem_din into byte lane i of the result register at edge E(i+1).
REQ-016 SHALL, for writes, drive mem_dout=wdata byte i with mem_wr=1 at edge Ei.
REQ-017 SHALL, at edge En:
- assert the owner's done for exactly one cycle;
- present the result on if_data or ls_rdata;
- drive mem_wr=0 and mem_a=0;
- go to COOL.
REQ-018 SHALL give latencies from grant edge to done edge of n edges: word read/write 4, half 2, byte 1.
REQ-019 SHALL keep if_data and ls_rdata stable between done pulses.
REQ-020 SHALL, in COOL, ignore all requests for one cycle and then return to IDLE, so the earliest regrant is E(n+2).
REQ-021 SHALL let the grant decision take precedence when if_req and ls_req rise in the same cycle; the loser is held and served later, never dropped.
REQ-022 SHALL, on flush_in=1 while BUSY with a fetch or an LSU read:
- abort the transaction;
- drive mem_wr=0 and mem_a=0;
- assert no done;
- go to IDLE, with no grant on that edge.
REQ-023 SHALL NOT abort an in-progress LSU write on flush_in; the write completes normally.
REQ-024 SHALL, on flush_in in IDLE or COOL, block any grant on that edge.
REQ-025 SHALL, on rdy_in=0, hold all state and outputs; done pulses are neither lost nor repeated.
REQ-026 SHALL never issue a new transaction while BUSY; a change on a req input mid-transaction has no effect.

Reset
REQ-027 SHALL, on rst_in=1 at a clock edge, set the following regardless of rdy_in or an in-flight transaction:
- state=IDLE, cnt=0, lsu_streak=0;
- mem_wr=0, mem_a=0, mem_dout=0;
- if_done=0, ls_done=0, if_data=0, ls_rdata=0.
REQ-028 SHALL produce no done pulse for a transaction cut off by reset.

Verification
REQ-029 SHALL verify a fetch word read:
- stimulus: if_addr=0x100, RAM bytes 0x13,0x05,0x10,0x00;
- response: mem_a=0x100..0x103 on E0..E3, if_done pulse at E4, if_data=0x00100513.
REQ-030 SHALL verify an LSU write half:
- stimulus: ls_addr=0x2000, ls_wdata=0xAABBCCDD, ls_size=1;
- response: mem_wr=1 with (0x2000,0xDD) then (0x2001,0xCC), ls_done at E2, mem_wr=0 afterwards.
REQ-031 SHALL verify simultaneous requests:
- stimulus: if_req and ls_req both held high;
- response: grant order LSU, LSU, FETCH, LSU, LSU, FETCH.
REQ-032 SHALL verify flush mid-fetch:
- stimulus: flush_in=1 at E2 of a fetch;
- response: no if_done, IDLE next cycle, mem_a=0.
- a flush at E1 of an LSU write still yields ls_done at E4.
REQ-033 SHALL verify a stall:
- stimulus: rdy_in=0 for 3 cycles after E1 of a word read;
- response: mem_a holds, if_done occurs exactly once, if_data correct.
REQ-034 SHALL verify address wrap and reset:
- ls_addr=0xFFFFFFFE with a word read gives mem_a FFFFFFFE, FFFFFFFF, 00000000, 00000001;
- rst_in at E2 gives all outputs 0 and no done.
